cic_decim_pcm: RTL and testbench

CIC_DECIM_PCM -- requirements
Module: cic_decim_pcm

---
 rtl/cic_decim_pcm_pkg.sv | 8 +
 rtl/cic_comb_stage.sv | 17 +
 rtl/cic_decim_pcm.sv | 90 +++++++++
 tb/tb_cic_decim_pcm.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/cic_decim_pcm_pkg.sv
// cic_decim_pcm_pkg: shared CIC decimator defaults and derived widths.
package cic_decim_pcm_pkg;
   localparam int CIC_ORDER  = 4;
   localparam int CIC_LOG2_R = 5;
   localparam int CIC_OUT_W  = 24;
   localparam int CIC_REG_W  = 2 + CIC_ORDER * CIC_LOG2_R;
   localparam int CIC_S      = CIC_OUT_W - 1 - CIC_ORDER * CIC_LOG2_R;
endpackage

// File: rtl/cic_comb_stage.sv
// cic_comb_stage: one CIC differentiator, y = x - x_delayed; the delay loads x on en.
module cic_comb_stage #(
   parameter int W = 22
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic signed [W-1:0] x,
   output logic signed [W-1:0] y
);
   logic signed [W-1:0] d;
   always_ff @(posedge clk) begin
      if (!rst_n) d <= '0;
      else if (en) d <= x;
   end
   assign y = x - d;
endmodule

// File: rtl/cic_decim_pcm.sv
// cic_decim_pcm: ORDER-stage CIC decimator turning a 1-bit delta-sigma stream
// into saturated signed PCM, one sample per 2^LOG2_R accepted bits.
module cic_decim_pcm
   import cic_decim_pcm_pkg::*;
#(
   parameter int ORDER  = CIC_ORDER,
   parameter int LOG2_R = CIC_LOG2_R,
   parameter int OUT_W  = CIC_OUT_W
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    bit_in,
   input  logic                    bit_valid,
   output logic signed [OUT_W-1:0] out,
   output logic                    out_valid,
   output logic                    sat
);
   localparam int REG_W = 2 + ORDER * LOG2_R;
   localparam int S     = OUT_W - 1 - ORDER * LOG2_R;
   localparam int SP    = S > 0 ? S : 0;
   localparam int SN    = S < 0 ? -S : 0;
   localparam int SW    = REG_W + SP + 1;
   localparam int WU_W  = $clog2(ORDER + 1);
   localparam logic [WU_W-1:0] WU_MAX = WU_W'(ORDER);
   localparam logic signed [SW-1:0] HI = {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [SW-1:0] LO = {{(SW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   logic signed [1:0]       x2;
   logic signed [REG_W-1:0] acc;
   logic signed [REG_W-1:0] integ [ORDER];
   logic signed [REG_W-1:0] integ_nxt [ORDER];
   logic [LOG2_R-1:0]       cnt;
   logic [WU_W-1:0]         warm;
   logic                    frame, hi, lo;
   logic signed [SW-1:0]    sc;

   assign x2 = bit_in ? 2'sb01 : 2'sb11;

   // Delay-free cascade: every integrator sees this edge's new upstream value,
   // so the decimated output is exactly the textbook CIC response.
   always_comb begin
      acc = REG_W'(x2);
      for (int k = 0; k < ORDER; k++) begin
         acc          = acc + integ[k];
         integ_nxt[k] = acc;
      end
   end

   for (genvar k = 0; k < ORDER; k++) begin : g_c
      logic signed [REG_W-1:0] x, y;
      if (k == 0) begin : g_h
         assign x = integ[ORDER-1];
      end else begin : g_t
         assign x = g_c[k-1].y;
      end
      cic_comb_stage #(.W(REG_W)) u_comb (
         .clk  (clk),
         .rst_n(rst_n),
         .en   (frame),
         .x    (x),
         .y    (y)
      );
   end

   assign sc = (SW'(g_c[ORDER-1].y) <<< SP) >>> SN;
   assign hi = sc > HI;
   assign lo = sc < LO;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < ORDER; k++) integ[k] <= '0;
         cnt       <= '0;
         warm      <= '0;
         frame     <= 1'b0;
         out       <= '0;
         out_valid <= 1'b0;
         sat       <= 1'b0;
      end else begin
         if (bit_valid) begin
            for (int k = 0; k < ORDER; k++) integ[k] <= integ_nxt[k];
            cnt <= cnt + 1'b1;
         end
         frame     <= bit_valid && (&cnt);
         out_valid <= frame && warm == WU_MAX;
         sat       <= frame && warm == WU_MAX && (hi || lo);
         if (frame && warm != WU_MAX) warm <= warm + 1'b1;
         if (frame && warm == WU_MAX) out <= hi ? HI[OUT_W-1:0] : lo ? LO[OUT_W-1:0] : sc[OUT_W-1:0];
      end
   end
endmodule

// File: tb/tb_cic_decim_pcm.sv
// tb_cic_decim_pcm: table vectors, reset corner case and random stream checked
// against a convolution model of the CIC impulse response.
module tb_cic_decim_pcm;
   import cic_decim_pcm_pkg::*;
   localparam int R  = 1 << CIC_LOG2_R;
   localparam int HL = CIC_ORDER * (R - 1) + 1;
   localparam int SP = CIC_S > 0 ? CIC_S : 0;
   localparam int SN = CIC_S < 0 ? -CIC_S : 0;
   localparam longint MAXV = (64'sd1 <<< (CIC_OUT_W - 1)) - 1;
   localparam longint MINV = -MAXV - 1;

   typedef struct {
      int     mode;
      int     per;
      longint eo;
      logic   es;
      int     gap;
   } vec_t;

   logic clk = 0, rst_n = 0, bit_in = 0, bit_valid = 0;
   logic signed [CIC_OUT_W-1:0] out;
   logic out_valid, sat;
   int total = 0, bad = 0;
   longint h [HL];
   longint t [HL];
   int hist [$];
   logic pend_v = 0, pend_s = 0, exp_v = 0, exp_s = 0;
   longint pend_o = 0, exp_o = 0;
   vec_t vt [4];

   cic_decim_pcm dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bit_in   (bit_in),
      .bit_valid(bit_valid),
      .out      (out),
      .out_valid(out_valid),
      .sat      (sat)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input longint a, input longint e);
      total++;
      if (a != e) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, a, e);
      end
   endtask

   // Model: output of frame m is the CIC impulse response convolved with the
   // +/-1 history ending at bit m*R-1, zero before reset release.
   task automatic accept(input logic b);
      longint a, sc;
      hist.push_back(b ? 1 : -1);
      if (hist.size() % R != 0 || hist.size() / R <= CIC_ORDER) return;
      a = 0;
      for (int j = 0; j < HL && j < hist.size(); j++) a += h[j] * hist[hist.size() - 1 - j];
      sc = (a <<< SP) >>> SN;
      pend_v = 1;
      pend_s = sc > MAXV || sc < MINV;
      pend_o = sc > MAXV ? MAXV : sc < MINV ? MINV : sc;
   endtask

   task automatic step(input logic b, input logic v);
      bit_in = b;
      bit_valid = v;
      @(posedge clk);
      #1;
      exp_v = pend_v;
      exp_s = pend_v & pend_s;
      if (pend_v) exp_o = pend_o;
      pend_v = 0;
      chk("out_valid", out_valid, exp_v);
      chk("sat", sat, exp_s);
      chk("out", out, exp_o);
      if (v) accept(b);
   endtask

   task automatic do_reset();
      rst_n = 0;
      bit_in = 1;
      bit_valid = 1;
      @(posedge clk);
      #1;
      hist.delete();
      pend_v = 0;
      exp_o = 0;
      chk("rst_out", out, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_sat", sat, 0);
      rst_n = 1;
   endtask

   task automatic run_vec(input vec_t vv);
      int k, ns, prev;
      logic b, v;
      k = 0;
      ns = 0;
      prev = 0;
      do_reset();
      for (int i = 1; i <= 7 * R * vv.per + 2; i++) begin
         v = (i % vv.per) == 0;
         b = vv.mode == 0 ? 1'b0 : vv.mode == 1 ? 1'b1 : (k % 2 == 0);
         step(b, v);
         if (v) k++;
         if (out_valid) begin
            chk("tbl_out", out, vv.eo);
            chk("tbl_sat", sat, vv.es);
            if (ns == 0) chk("tbl_first", i, (CIC_ORDER + 1) * R * vv.per + 1);
            else chk("tbl_gap", i - prev, vv.gap);
            prev = i;
            ns++;
         end
      end
      chk("tbl_count", ns, 3);
   endtask

   initial begin
      int n;
      for (int i = 0; i < HL; i++) h[i] = 0;
      h[0] = 1;
      repeat (CIC_ORDER) begin
         for (int i = 0; i < HL; i++) begin
            t[i] = 0;
            for (int k = 0; k < R; k++) if (i >= k) t[i] += h[i - k];
         end
         h = t;
      end
      vt[0] = '{0, 1, -8388608, 1'b0, 32};
      vt[1] = '{1, 1, 8388607, 1'b1, 32};
      vt[2] = '{2, 1, 0, 1'b0, 32};
      vt[3] = '{1, 3, 8388607, 1'b1, 96};
      for (int i = 0; i < 4; i++) run_vec(vt[i]);

      do_reset();
      for (int i = 0; i < 5 * R + 18; i++) step(1, 1);
      do_reset();
      n = 0;
      do begin
         step(1, 1);
         n++;
      end while (!out_valid && n < 400);
      chk("rst_first_strobe", n, (CIC_ORDER + 1) * R + 1);
      chk("rst_first_val", out, MAXV);

      do_reset();
      for (int i = 0; i < 20000; i++) step(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
      step(0, 0);
      step(0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
